rotate_sequencer: RTL and testbench

Command-driven controller that sequences an embedded WIDTH-bit load/rotate/shift register. It accepts one command at a time over a valid/ready handshake and parallel-loads the operand. It then steps the register one position per cycle in the requested direction and mode, and pulses `done` when the result is final. It sits between the lab's switch/key front end (or a test driver) and the LED display.

---
 rtl/rotate_sequencer.sv | 121 ++++++++++++
 tb/tb_rotate_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rotate_sequencer
// Description : Command-driven sequencer for a WIDTH-bit load/rotate/shift
//               register. Accepts one command over valid/ready, parallel-loads
//               the operand, steps it one position per enabled cycle, then
//               pulses done for one cycle with the final value on q.
//               Optional feature macro: ROTSEQ_PACE_EN (adds step_tick input;
//               steps in SHIFT occur only on edges where step_tick is high).
// Revision    : 1.0 - initial release
// ============================================================================
module rotate_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             Clock,
    input  logic             Reset_b,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [AMT_W-1:0] cmd_amount,
    input  logic             cmd_right,
    input  logic             cmd_shift,
`ifdef ROTSEQ_PACE_EN
    input  logic             step_tick,
`endif
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    localparam logic [AMT_W-1:0] CNT_ONE = {{(AMT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   q_q;
    logic [AMT_W-1:0]   cnt_q;
    logic               right_q;
    logic               shift_q;
    logic               done_q;
    logic [WIDTH-1:0]   step_d;
    logic               step_en;

`ifdef ROTSEQ_PACE_EN
    assign step_en = step_tick;
`else
    assign step_en = 1'b1;
`endif

    // One-position move of the register in the captured direction and mode
    always_comb begin
        step_d = q_q;
        case ({right_q, shift_q})
            2'b10:   step_d = {q_q[0], q_q[WIDTH-1:1]};       // right rotate
            2'b11:   step_d = {1'b0, q_q[WIDTH-1:1]};         // right shift
            2'b00:   step_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; // left rotate
            default: step_d = {q_q[WIDTH-2:0], 1'b0};         // left shift
        endcase
    end

    // Control FSM with datapath; done is registered and set on entry to DONE
    always_ff @(posedge Clock) begin
        if (Reset_b) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            right_q <= 1'b0;
            shift_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (cmd_valid) begin
                        q_q     <= cmd_data;
                        cnt_q   <= cmd_amount;
                        right_q <= cmd_right;
                        shift_q <= cmd_shift;
                        if (cmd_amount != '0) begin
                            state_q <= S_SHIFT;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (step_en) begin
                        q_q   <= step_d;
                        cnt_q <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign q         = q_q;
    assign done      = done_q;
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rotate_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rotate_sequencer
// Description : Self-checking bench for rotate_sequencer (WIDTH=8, AMT_W=4)
//               against an arithmetic reference model of rotate/shift by k.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rotate_sequencer;

    localparam int W = 8;

    logic         Clock = 1'b0;
    logic         Reset_b = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [W-1:0] cmd_data = '0;
    logic [3:0]   cmd_amount = '0;
    logic         cmd_right = 1'b0;
    logic         cmd_shift = 1'b0;
    logic         step_tick = 1'b1;
    logic [W-1:0] q;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clock = ~Clock;

    rotate_sequencer #(.WIDTH(W), .AMT_W(4)) dut (
        .Clock      (Clock),
        .Reset_b    (Reset_b),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .cmd_amount (cmd_amount),
        .cmd_right  (cmd_right),
        .cmd_shift  (cmd_shift),
`ifdef ROTSEQ_PACE_EN
        .step_tick  (step_tick),
`endif
        .q          (q),
        .busy       (busy),
        .done       (done)
    );

    // Result of applying k single-position moves to d, from whole-operation arithmetic
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input int k,
                                           input bit right, input bit shift);
        logic [2*W-1:0] dd;
        logic [2*W-1:0] t;
        int m;
        if (shift) begin
            if (k >= W) return '0;
            dd = {{W{1'b0}}, d};
            t  = right ? (dd >> k) : (dd << k);
            return t[W-1:0];
        end
        m  = k % W;
        dd = {d, d};
        if (right) begin
            t = dd >> m;
            return t[W-1:0];
        end
        t = dd << m;
        return t[2*W-1:W];
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Waits (bounded) for cmd_ready, then presents a command for exactly one edge
    task automatic send(input logic [W-1:0] d, input logic [3:0] amt,
                        input bit right, input bit shift);
        int guard = 0;
        while (!cmd_ready && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        cmd_valid  = 1'b1;
        cmd_data   = d;
        cmd_amount = amt;
        cmd_right  = right;
        cmd_shift  = shift;
        step();
        cmd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        Reset_b = 1'b1; cmd_valid = 1'b1; cmd_data = 8'hFF; cmd_amount = 4'd3;
        step();
        Reset_b = 1'b0; cmd_valid = 1'b0;
        n_checks++;
        if ({q, cmd_ready, busy, done} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: q=%h rdy=%b busy=%b done=%b required 00 1 0 0", q, cmd_ready, busy, done);
        end
        step();
        n_checks++;
        if (q !== 8'h00 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cmd_not_taken: q=%h rdy=%b required 00 1", q, cmd_ready);
        end
    endtask

    task automatic test_rotate_right();
        send(8'hA5, 4'd1, 1'b1, 1'b0);
        n_checks++;
        if (q !== 8'hA5 || done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_load: q=%h done=%b busy=%b required a5 0 1", q, done, busy);
        end
        step();
        n_checks++;
        if (q !== 8'hD2 || done !== 1'b1 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_done: q=%h done=%b rdy=%b required d2 1 0", q, done, cmd_ready);
        end
        step();
        n_checks++;
        if (q !== 8'hD2 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_ready: q=%h done=%b rdy=%b required d2 0 1", q, done, cmd_ready);
        end
    endtask

    task automatic test_sequences();
        logic [W-1:0] td [3] = '{8'h81, 8'hF0, 8'hFF};
        int           ta [3] = '{3, 4, 9};
        bit           tr [3] = '{1'b0, 1'b1, 1'b1};
        bit           ts [3] = '{1'b0, 1'b1, 1'b1};
        logic [W-1:0] fin [3] = '{8'h0C, 8'h0F, 8'h00};
        for (int i = 0; i < 3; i++) begin
            send(td[i], 4'(ta[i]), tr[i], ts[i]);
            for (int k = 1; k <= ta[i]; k++) begin
                step();
                n_checks++;
                if (q !== model(td[i], k, tr[i], ts[i]) || done !== (k == ta[i])) begin
                    n_fail++;
                    $display("FAIL seq%0d_step%0d: q=%h done=%b required %h %b", i, k, q, done,
                             model(td[i], k, tr[i], ts[i]), (k == ta[i]));
                end
            end
            n_checks++;
            if (q !== fin[i]) begin
                n_fail++;
                $display("FAIL seq%0d_final: q=%h required %h", i, q, fin[i]);
            end
        end
        step();
    endtask

    task automatic test_zero_amount();
        send(8'h3C, 4'd0, 1'b0, 1'b0);
        n_checks++;
        if (q !== 8'h3C || done !== 1'b1 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: q=%h done=%b rdy=%b required 3c 1 0", q, done, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_data = 8'h55; cmd_amount = 4'd0;
        step();
        n_checks++;
        if (q !== 8'h3C || done !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_no_accept_in_done: q=%h done=%b rdy=%b required 3c 0 1", q, done, cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
        n_checks++;
        if (q !== 8'h55 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_accept_after_idle: q=%h done=%b required 55 1", q, done);
        end
        step();
    endtask

    task automatic test_reset_mid_shift();
        send(8'h01, 4'd8, 1'b0, 1'b0);
        step(); step(); step();
        n_checks++;
        if (q !== 8'h08) begin
            n_fail++;
            $display("FAIL abort_pre: q=%h required 08", q);
        end
        Reset_b = 1'b1;
        step();
        Reset_b = 1'b0;
        n_checks++;
        if (q !== 8'h00 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset: q=%h rdy=%b done=%b required 00 1 0", q, cmd_ready, done);
        end
        step();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: done=%b required 0", done);
        end
        send(8'h12, 4'd2, 1'b1, 1'b0);
        step(); step();
        n_checks++;
        if (q !== 8'h84 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_followup: q=%h done=%b required 84 1", q, done);
        end
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] d  = W'($urandom);
            int           a  = $urandom_range(0, 15);
            bit           r  = 1'($urandom);
            bit           s  = 1'($urandom);
            send(d, 4'(a), r, s);
            // scramble command inputs while busy; they must be ignored
            cmd_data = W'($urandom); cmd_amount = 4'($urandom);
            cmd_right = 1'($urandom); cmd_shift = 1'($urandom);
            n_checks++;
            if (q !== d || done !== (a == 0) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd%0d_load: q=%h done=%b busy=%b required %h %b 1", i, q, done, busy, d, (a == 0));
            end
            for (int k = 1; k <= a; k++) begin
                step();
                n_checks++;
                if (q !== model(d, k, r, s) || done !== (k == a) || cmd_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd%0d_step%0d: q=%h done=%b rdy=%b required %h %b 0", i, k, q, done,
                             cmd_ready, model(d, k, r, s), (k == a));
                end
            end
            step();
            n_checks++;
            if (cmd_ready !== 1'b1 || done !== 1'b0 || q !== model(d, a, r, s)) begin
                n_fail++;
                $display("FAIL rnd%0d_end: q=%h rdy=%b done=%b required %h 1 0", i, q, cmd_ready, done,
                         model(d, a, r, s));
            end
        end
    endtask

`ifdef ROTSEQ_PACE_EN
    task automatic test_pace();
        int taken = 0;
        bit tick;
        step_tick = 1'b0;
        send(8'h80, 4'd2, 1'b1, 1'b0);
        for (int c = 1; c <= 12 && taken < 2; c++) begin
            tick = (c % 3 == 0);
            step_tick = tick;
            step();
            if (tick) taken++;
            n_checks++;
            if (q !== model(8'h80, taken, 1'b1, 1'b0) || done !== (tick && taken == 2)) begin
                n_fail++;
                $display("FAIL pace_c%0d: q=%h done=%b required %h %b", c, q, done,
                         model(8'h80, taken, 1'b1, 1'b0), (tick && taken == 2));
            end
        end
        step_tick = 1'b1;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_rotate_right();
        test_sequences();
        test_zero_amount();
        test_reset_mid_shift();
        test_random();
`ifdef ROTSEQ_PACE_EN
        test_pace();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
